// File: rtl/router_pkg.sv
// Shared router definitions: flit layout, slot indices, eligibility helper.
package router_pkg;
  localparam int         NUM_SLOTS  = 4;
  localparam int         FLIT_W     = 32;
  localparam logic [2:0] LOCAL_PORT = 3'b100;
  localparam int         VALID_BIT  = 1;
  localparam int         OPORT_MSB  = 6;
  localparam int         OPORT_LSB  = 4;

  localparam logic [1:0] SLOT_N = 2'd0;
  localparam logic [1:0] SLOT_E = 2'd1;
  localparam logic [1:0] SLOT_S = 2'd2;
  localparam logic [1:0] SLOT_W = 2'd3;

  typedef logic [FLIT_W-1:0] flit_t;

  // A flit wants to eject when it is valid and requests the local port.
  function automatic logic is_local(flit_t f);
    return f[VALID_BIT] && (f[OPORT_MSB:OPORT_LSB] == LOCAL_PORT);
  endfunction
endpackage

// File: rtl/eject_scheduler_if.sv
// Ejection handshake toward the local PE.
interface eject_scheduler_if;
  import router_pkg::*;
  flit_t ej_flit;
  logic  ej_valid;
  logic  ej_ready;

  modport master (output ej_flit, output ej_valid, input ej_ready);
  modport slave  (input ej_flit, input ej_valid, output ej_ready);
endinterface

// File: rtl/eject_fifo.sv
// DEPTH x 32 FIFO with registered fall-through head; push while full is
// accepted only when a pop happens in the same cycle.
module eject_fifo
  import router_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push,
  input  flit_t push_data,
  input  logic  pop,
  output logic  full,
  output logic  empty,
  output flit_t head
);
  localparam int AW = $clog2(DEPTH);

  flit_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage, pointers (wrap naturally mod DEPTH) and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/eject_scheduler.sv
// Round-robin ejection of one local-destined flit per cycle into a small
// FIFO; the ejected slot's valid bit is killed in the registered pass-through.
module eject_scheduler
  import router_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  flit_t            in_n,
  input  flit_t            in_e,
  input  flit_t            in_s,
  input  flit_t            in_w,
  output flit_t            out_n,
  output flit_t            out_e,
  output flit_t            out_s,
  output flit_t            out_w,
  eject_scheduler_if.master ej,
  output logic             ej_blocked,
  output logic [CNT_W-1:0] eject_cnt
);
  logic [NUM_SLOTS-1:0][FLIT_W-1:0] in_v, out_d, out_q;
  logic [NUM_SLOTS-1:0]             elig;
  logic [1:0]                       rr_ptr, win, idx;
  logic                             any_elig, grant_en, grant, pop, full, empty;

  assign in_v = {in_w, in_s, in_e, in_n};

  // Eligibility per fixed slot index (never the flit's own inport field).
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_SLOTS; i++) elig[i] = is_local(in_v[i]);
  end

  // First eligible slot searching from rr_ptr upward, mod 4.
  always_comb begin
    win      = rr_ptr;
    idx      = rr_ptr;
    any_elig = 1'b0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      idx = rr_ptr + 2'(k);
      if (!any_elig && elig[idx]) begin
        win      = idx;
        any_elig = 1'b1;
      end
    end
  end

  // A full FIFO can still take a flit if the PE drains the head this cycle.
  assign pop      = !empty && ej.ej_ready;
  assign grant_en = !full || pop;
  assign grant    = any_elig && grant_en;

  // Pass-through with only the granted slot's valid bit cleared.
  always_comb begin
    out_d = in_v;
    if (grant) out_d[win][VALID_BIT] = 1'b0;
  end

  // Output registers, arbitration pointer, blocked pulse, saturating counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q      <= '0;
      rr_ptr     <= '0;
      ej_blocked <= 1'b0;
      eject_cnt  <= '0;
    end else begin
      out_q      <= out_d;
      ej_blocked <= any_elig && !grant_en;
      if (grant) rr_ptr <= win + 2'd1;
      if (grant && (eject_cnt != '1)) eject_cnt <= eject_cnt + 1'b1;
    end
  end

  assign out_n = out_q[SLOT_N];
  assign out_e = out_q[SLOT_E];
  assign out_s = out_q[SLOT_S];
  assign out_w = out_q[SLOT_W];

  eject_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (grant),
    .push_data (in_v[win]),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head      (ej.ej_flit)
  );

  assign ej.ej_valid = !empty;
endmodule

// File: doc/eject_scheduler.md
# eject_scheduler

Clocked ejection controller for the router's local port. Each cycle it does four things:
- examines the four incoming flits (N, E, S, W);
- picks at most one valid local-destined flit with a round-robin pointer;
- kills that flit's valid bit in the registered pass-through;
- pushes it into a small ejection FIFO drained by the local PE over a valid/ready handshake.

It sits between the input pipeline registers and the deflection/route stage. It replaces fixed-priority ejection with fair, back-pressured ejection.

## Interface
- DEPTH, 2, ejection FIFO entries (power of two, ≥2)
- CNT_W, 16, width of the ejection statistics counter
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_n, in_e, in_s, in_w  in  32 each  incoming flits from the N, E, S, W ports
- out_n, out_e, out_s, out_w  out  32 each  registered pass-through flits, with the ejected slot killed
- ej_flit  out  32  FIFO head flit toward the local PE
- ej_valid  out  1  FIFO non-empty
- ej_ready  in  1  PE accepts the head this cycle
- ej_blocked  out  1  registered pulse: an eligible flit existed but no push was possible
- eject_cnt  out  CNT_W  saturating count of flits pushed

## Operation
- Flit fields:
  - [1] is the valid bit.
  - [3:2] is the input port: N=00, E=01, S=10, W=11.
  - [6:4] is the output port request; 3'b100 means local.
- A slot is eligible when in_x[1]==1 and in_x[6:4]==3'b100.
- Slot index is fixed: N=0, E=1, S=2, W=3. Arbitration and kill use the slot index, never [3:2].
- Round-robin:
  - The 2-bit pointer rr_ptr resets to 0.
  - The search order is rr_ptr, rr_ptr+1, … mod 4, and the first eligible slot wins.
  - On a grant, rr_ptr becomes winner+1 mod 4. With no grant, rr_ptr holds.
- Grant enable: the FIFO is not full, or it is full and a pop occurs this cycle (ej_valid && ej_ready).
- If any slot is eligible but the grant is disabled:
  - there is no grant and rr_ptr holds;
  - ej_blocked=1 on the next cycle;
  - all flits pass through unmodified, so the route stage deflects them.
- Kill: out_x is in_x registered. For the granted slot only, bit [1] is forced to 0. All other bits are unchanged.
- FIFO:
  - Push the granted flit unmodified (valid bit still 1).
  - Pop when ej_valid && ej_ready.
  - Push and pop in the same cycle are allowed at any occupancy, including full.
  - A pop when empty is ignored.
- eject_cnt increments by 1 per push and saturates at 2^CNT_W−1.

## Timing
- Reset (asynchronous, rst_n=0) clears:
  - out_* = 0, ej_flit = 0, ej_valid = 0, ej_blocked = 0, eject_cnt = 0;
  - rr_ptr = 0 and FIFO pointers/occupancy = 0.
- Pass-through latency: in_x at edge k appears on out_x after edge k (1 cycle).
- Ejection latency: a flit granted at edge k gives ej_valid=1 after edge k when the FIFO was empty (first-word fall-through from the registered head).
- ej_flit is stable while ej_valid && !ej_ready.
- Handshake: the PE may hold ej_ready high continuously, and ej_ready may toggle freely. There is no combinational path from ej_ready to ej_valid.
- The grant path depends combinationally on ej_ready. This is the only in-to-reg combinational dependency on the handshake.
- Reset asserted mid-operation: all in-flight FIFO contents are discarded. There is no recovery of ejected-but-unconsumed flits.
- Simultaneous grant and pop when full: occupancy stays DEPTH, the head advances, and the new flit enters at the tail.
- Wrap-around:
  - FIFO pointers wrap mod DEPTH.
  - rr_ptr wraps from 3 to 0.

## Structure
- Shared package router_pkg holds:
  - the constants LOCAL_PORT=3'b100, VALID_BIT=1, OPORT_MSB=6, OPORT_LSB=4;
  - the slot indices N/E/S/W;
  - a flit_t 32-bit typedef.
- One sub-module: eject_fifo, a DEPTH×32 synchronous FIFO with push/pop, full/empty and fall-through head.
- The round-robin arbiter and kill logic stay in the top level.

## Test plan
- Reset: hold rst_n=0 with random inputs. Required: all outputs 0. Release: ej_valid=0, eject_cnt=0.
- Single eligible flit: in_e=32'h0000_0042 (oport 100, valid). Required:
  - the next cycle shows out_e=32'h0000_0040 and ej_valid=1 with ej_flit=32'h0000_0042;
  - eject_cnt=1;
  - the other out_* equal their inputs.
- Round-robin fairness: all four slots eligible for 4 consecutive cycles, ej_ready=1. Required: grant order N, E, S, W, and rr_ptr returns to 0.
- Back-pressure: ej_ready=0, with one eligible flit per cycle for 4 cycles (DEPTH=2). Required:
  - the first 2 are pushed;
  - on cycles 3–4, ej_blocked=1 and no kill is applied;
  - eject_cnt=2.
- Full with simultaneous pop: FIFO full, ej_ready=1, one eligible flit. Required:
  - push accepted;
  - occupancy stays 2;
  - the head advances in order;
  - ej_blocked=0.
- Non-local and invalid flits: in_n oport 3'b001 valid, and in_s oport 3'b100 with bit [1]=0. Required: no grant, outputs pass unchanged, ej_blocked=0.
